// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared widths and run-controller state encodings.
package cpu_run_ctrl_pkg;
  localparam int INSTRUCTION_SIZE = 32;
  localparam int RUNCTRL_STATE_W = 2;
  typedef enum logic [RUNCTRL_STATE_W-1:0] {
    RUNCTRL_HALT  = 2'd0,
    RUNCTRL_RUN   = 2'd1,
    RUNCTRL_STEP  = 2'd2,
    RUNCTRL_BREAK = 2'd3
  } runctrl_state_e;
endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-level counter and single-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk100MHz,
  input  logic rst,
  input  logic btn_raw,
  output logic press_p
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_accept;
  assign w_differ = r_sync[1] != r_level;
  assign w_accept = w_differ && r_cnt == CW'(DEBOUNCE_CYCLES);
  // r_level flips only after the opposite level has persisted, so release also needs to be stable
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], btn_raw};
      r_press <= w_accept & r_sync[1];
      r_level <= w_accept ? r_sync[1] : r_level;
      r_cnt   <= (w_differ && !w_accept) ? r_cnt + CW'(1) : '0;
    end
  end
  assign press_p = r_press;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint controller producing the core clock-enable pulse train.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int TICK_DIV        = 5000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int XLEN            = INSTRUCTION_SIZE
) (
  input  logic                       clk100MHz,
  input  logic                       rst,
  input  logic                       btn_run,
  input  logic                       btn_halt,
  input  logic                       btn_step,
  input  logic                       bp_en,
  input  logic [XLEN-1:0]            bp_addr,
  input  logic [XLEN-1:0]            pc_in,
  output logic                       cpu_ce,
  output logic [RUNCTRL_STATE_W-1:0] state,
  output logic                       bp_hit,
  output logic [XLEN-1:0]            step_count
);
  localparam int TW = $clog2(TICK_DIV);
  logic           w_run_p, w_halt_p, w_step_p;
  logic           w_step_sel, w_run_sel, w_tick, w_bp_match;
  logic           w_ce, w_skip;
  logic [TW-1:0]  w_tick_nxt, r_tick;
  runctrl_state_e w_state, r_state;
  logic           r_skip, r_ce, r_bp_hit;
  logic [XLEN-1:0] r_count;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk100MHz(clk100MHz), .rst(rst), .btn_raw(btn_run), .press_p(w_run_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt (
    .clk100MHz(clk100MHz), .rst(rst), .btn_raw(btn_halt), .press_p(w_halt_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk100MHz(clk100MHz), .rst(rst), .btn_raw(btn_step), .press_p(w_step_p));

  assign w_step_sel = w_step_p & ~w_halt_p;
  assign w_run_sel  = w_run_p & ~w_halt_p & ~w_step_p;
  assign w_tick     = r_tick == TW'(TICK_DIV - 1);
  assign w_bp_match = bp_en && pc_in == bp_addr && !r_skip;

  // tick counter defaults to 0, so it only advances while staying in RUN
  always_comb begin
    w_state    = r_state;
    w_ce       = 1'b0;
    w_skip     = r_skip;
    w_tick_nxt = '0;
    case (r_state)
      RUNCTRL_HALT:
        if (w_step_sel) begin
          w_state = RUNCTRL_STEP;
          w_ce    = 1'b1;
        end else if (w_run_sel) begin
          w_state = RUNCTRL_RUN;
          w_skip  = 1'b0;
        end
      RUNCTRL_RUN:
        if (w_halt_p) w_state = RUNCTRL_HALT;
        else if (!w_tick) w_tick_nxt = r_tick + TW'(1);
        else if (w_bp_match) w_state = RUNCTRL_BREAK;
        else begin
          w_ce   = 1'b1;
          w_skip = 1'b0;
        end
      RUNCTRL_STEP: w_state = RUNCTRL_HALT;
      default:
        if (w_halt_p) w_state = RUNCTRL_HALT;
        else if (w_step_sel) begin
          w_state = RUNCTRL_STEP;
          w_ce    = 1'b1;
        end else if (w_run_sel) begin
          w_state = RUNCTRL_RUN;
          w_skip  = 1'b1;
        end
    endcase
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_state  <= RUNCTRL_HALT;
      r_tick   <= '0;
      r_skip   <= 1'b0;
      r_ce     <= 1'b0;
      r_bp_hit <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state;
      r_tick   <= w_tick_nxt;
      r_skip   <= w_skip;
      r_ce     <= w_ce;
      r_bp_hit <= w_state == RUNCTRL_BREAK;
      r_count  <= r_count + XLEN'(r_ce);
    end
  end

  assign cpu_ce     = r_ce;
  assign state      = r_state;
  assign bp_hit     = r_bp_hit;
  assign step_count = r_count;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed scenarios checked every cycle against a timestamp-based behavioural model.
module tb_cpu_run_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;

  logic        clk100MHz = 1'b0;
  logic        rst;
  logic [2:0]  btn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_in;
  logic        pc_clr;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] step_count;

  int checks = 0;
  int errors = 0;

  cpu_run_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk100MHz(clk100MHz), .rst(rst),
    .btn_run(btn[0]), .btn_halt(btn[1]), .btn_step(btn[2]),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_in(pc_in),
    .cpu_ce(cpu_ce), .state(state), .bp_hit(bp_hit), .step_count(step_count));

  always #5 clk100MHz = ~clk100MHz;

  // model: buttons as run lengths of synchronized samples, ticks as absolute edge numbers
  int          mcyc = 0;
  int          m_state, m_next;
  logic        m_ce, m_skip;
  logic [31:0] m_count;
  logic [2:0]  h1, h2, syn, lvl, last, pend;
  int          run_len [3];
  logic        hp, sp, rp;

  always @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      m_state = 0; m_ce = 0; m_count = 0; m_skip = 0; m_next = 0;
      h1 = 0; h2 = 0; lvl = 0; last = 0; pend = 0;
      for (int b = 0; b < 3; b++) run_len[b] = 0;
    end else begin
      mcyc++;
      m_count = m_count + 32'(m_ce);
      hp = pend[1];
      sp = pend[2] & !hp;
      rp = pend[0] & !hp & !pend[2];
      m_ce = 0;
      case (m_state)
        0: if (sp) begin m_state = 2; m_ce = 1; end
           else if (rp) begin m_state = 1; m_skip = 0; m_next = mcyc + TD; end
        1: if (hp) m_state = 0;
           else if (mcyc == m_next) begin
             m_next = m_next + TD;
             if (bp_en && pc_in == bp_addr && !m_skip) m_state = 3;
             else begin m_ce = 1; m_skip = 0; end
           end
        2: m_state = 0;
        default: if (hp) m_state = 0;
           else if (sp) begin m_state = 2; m_ce = 1; end
           else if (rp) begin m_state = 1; m_skip = 1; m_next = mcyc + TD; end
      endcase
      syn = h2; h2 = h1; h1 = btn;
      for (int b = 0; b < 3; b++) begin
        run_len[b] = (syn[b] == last[b]) ? run_len[b] + 1 : 1;
        last[b] = syn[b];
        if (syn[b] != lvl[b] && run_len[b] >= DB + 1) begin
          lvl[b] = syn[b];
          pend[b] = syn[b];
        end else pend[b] = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycw(input int n);
    repeat (n) begin
      @(negedge clk100MHz);
      #1;
    end
  endtask

  task automatic press(input int b, input int hold, input int rel);
    btn[b] = 1'b1;
    cycw(hold);
    btn[b] = 1'b0;
    cycw(rel);
  endtask

  task automatic wait_state(input int exp, input int lim, input string nm);
    int n = 0;
    while (int'(state) != exp && n < lim) begin
      cycw(1);
      n++;
    end
    chk(nm, 64'(state), 64'(exp));
  endtask

  int ce_total = 0, ncyc = 0, run_entry = 0, last_ce = -1, first_off = -1, bad_gaps = 0, wide = 0;
  logic [1:0] prev_state = 0;
  logic prev_ce = 0;
  int snap;
  int n;

  initial begin
    rst = 1'b1; btn = '0; bp_en = 1'b0; bp_addr = '0; pc_clr = 1'b1;
    fork
      forever begin
        @(negedge clk100MHz);
        chk("ce", 64'(cpu_ce), 64'(m_ce));
        chk("state", 64'(state), 64'(m_state));
        chk("bp_hit", 64'(bp_hit), 64'(m_state == 3));
        chk("step_count", 64'(step_count), 64'(m_count));
        ncyc++;
        if (state == 2'd1 && prev_state != 2'd1) begin run_entry = ncyc; last_ce = -1; end
        if (cpu_ce) begin
          ce_total++;
          if (prev_ce) wide++;
          if (state == 2'd1) begin
            if (last_ce < 0) first_off = ncyc - run_entry;
            else if (ncyc - last_ce != TD) bad_gaps++;
            last_ce = ncyc;
          end
        end
        prev_state = state;
        prev_ce = cpu_ce;
        if (pc_clr) pc_in = '0;
        else if (cpu_ce) pc_in = pc_in + 32'd4;
      end
    join_none
    cycw(5);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_ce", 64'(cpu_ce), 64'd0);
    chk("rst_count", 64'(step_count), 64'd0);
    chk("rst_bp_hit", 64'(bp_hit), 64'd0);
    rst = 1'b0;
    pc_clr = 1'b0;
    snap = ce_total;
    cycw(50);
    chk("idle_ce", 64'(ce_total - snap), 64'd0);
    chk("idle_state", 64'(state), 64'd0);
    chk("idle_count", 64'(step_count), 64'd0);

    for (int i = 0; i < 3; i++) begin
      press(2, 8, 8);
      chk("step_state", 64'(state), 64'd0);
      chk("step_count_i", 64'(step_count), 64'(i + 1));
    end
    chk("step_pulses", 64'(ce_total - snap), 64'd3);
    chk("step_width", 64'(wide), 64'd0);

    for (int i = 0; i < 5; i++) begin
      btn[0] = 1'b1; cycw(2);
      btn[0] = 1'b0; cycw(2);
    end
    cycw(10);
    chk("bounce_state", 64'(state), 64'd0);
    btn[0] = 1'b1; cycw(6); btn[0] = 1'b0;
    wait_state(1, 20, "hold_run");

    cycw(20);
    press(1, 8, 0);
    wait_state(0, 20, "halt_state");
    snap = ce_total;
    cycw(10);
    chk("no_ce_after_halt", 64'(ce_total - snap), 64'd0);
    chk("first_pulse_off", 64'(first_off), 64'(TD));
    chk("pulse_gaps", 64'(bad_gaps), 64'd0);

    pc_clr = 1'b1; cycw(1); pc_clr = 1'b0;
    bp_addr = 32'h10; bp_en = 1'b1;
    snap = ce_total;
    press(0, 8, 0);
    wait_state(3, 60, "bp_state");
    chk("bp_pulses", 64'(ce_total - snap), 64'd4);
    chk("bp_pc", 64'(pc_in), 64'h10);
    chk("bp_hit_lit", 64'(bp_hit), 64'd1);
    cycw(8);
    press(0, 8, 0);
    n = 0;
    while (pc_in != 32'h18 && n < 40) begin cycw(1); n++; end
    chk("resume_pc", 64'(pc_in), 64'h18);
    chk("resume_state", 64'(state), 64'd1);

    n = 0;
    while (m_next - mcyc != 3 && n < 10) begin cycw(1); n++; end
    chk("prio_align", 64'(m_next - mcyc), 64'd3);
    snap = ce_total;
    btn[1] = 1'b1; btn[2] = 1'b1;
    cycw(8);
    btn = '0;
    cycw(8);
    chk("prio_state", 64'(state), 64'd0);
    chk("prio_pulses", 64'(ce_total - snap), 64'd1);

    press(0, 8, 0);
    wait_state(1, 10, "rerun_state");
    n = 0;
    while (m_next - mcyc != 1 && n < 10) begin cycw(1); n++; end
    chk("rst_align", 64'(m_next - mcyc), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_ce", 64'(cpu_ce), 64'd0);
    chk("midrst_count", 64'(step_count), 64'd0);
    snap = ce_total;
    cycw(2);
    rst = 1'b0;
    cycw(6);
    chk("postrst_ce", 64'(ce_total - snap), 64'd0);
    chk("postrst_state", 64'(state), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
